// File: rtl/subservient_dbg_loader.sv
// -----------------------------------------------------------------------------
// subservient_dbg_loader
//
// Wishbone initiator for the subservient debug port. It packs an incoming byte
// stream (flash reader, UART RX, ...) into little-endian 32-bit words and
// writes them into SRAM through the SoC debug bus. While loading it holds the
// core in debug mode and in reset; once the image is written it releases both
// in the same cycle and raises o_done.
//
// Optional feature (macro SUBSERVIENT_LOADER_VERIFY_EN):
//   Every write is followed by a read-back of the same word. The returned data
//   is compared on the enabled byte lanes only. A mismatch raises o_err and
//   ends the load immediately. Without the macro there is no read-back,
//   o_err is tied low and i_wb_dbg_rdt is ignored.
//
// Parameters:
//   memsize       SRAM size in bytes (multiple of 4). Loading stops once the
//                 write address reaches memsize.
//   aw            width of the internal byte-address counter.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_start       single-cycle pulse that begins a load (from IDLE or DONE)
//   i_byte*       byte stream input: data, valid, last-byte marker
//   o_byte_ready  stream ready; a byte is taken when valid & ready
//   o_debug_mode  to the SoC i_debug_mode input
//   o_core_rst    core reset request (ORed with system reset outside)
//   o_wb_dbg_*    Wishbone initiator towards the SoC debug port
//   i_wb_dbg_rdt  read data (used only by the read-back feature)
//   i_wb_dbg_ack  Wishbone acknowledge
//   o_done        level: load complete
//   o_err         level: read-back mismatch (read-back feature only)
// -----------------------------------------------------------------------------
module subservient_dbg_loader #(
    parameter int memsize = 512,
    parameter int aw      = $clog2(memsize)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_debug_mode,
    output logic        o_core_rst,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    // Byte address of the last word that fits into the SRAM.
    localparam logic [aw-1:0] last_addr = aw'(memsize - 4);

    state_t          state;
    logic [1:0]      cnt;        // byte lane to be filled next
    logic [aw-1:0]   addr;       // byte address of the word being assembled
    logic            last_seen;  // final image byte is part of the current word
    logic            word_final; // current word is the last one of the load

    // The load ends after this word either because the stream said so or
    // because the word occupies the top of the SRAM.
    assign word_final = last_seen || (addr == last_addr);

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
    logic [31:0] lane_mask;
    logic        verify_ok;

    // Stale data in lanes that were never filled must not cause a mismatch,
    // so only the lanes with their byte enable set take part in the compare.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{o_wb_dbg_sel[i]}};
        end
    end

    assign verify_ok = ((i_wb_dbg_rdt ^ o_wb_dbg_dat) & lane_mask) == 32'h0;
`else
    // Read data has no consumer without the read-back feature.
    logic unused_rdt;
    assign unused_rdt = ^i_wb_dbg_rdt;
    assign o_err      = 1'b0;
`endif

    // NOTE: every register below is updated with non-blocking assignments so
    // all state changes of one clock edge see the values from before that edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // Asynchronous reset also drops a strobe that is in flight.
            state        <= S_IDLE;
            cnt          <= 2'd0;
            addr         <= '0;
            last_seen    <= 1'b0;
            o_byte_ready <= 1'b0;
            o_debug_mode <= 1'b0;
            o_core_rst   <= 1'b0;
            o_wb_dbg_adr <= 32'h0;
            o_wb_dbg_dat <= 32'h0;
            o_wb_dbg_sel <= 4'h0;
            o_wb_dbg_we  <= 1'b0;
            o_wb_dbg_stb <= 1'b0;
            o_done       <= 1'b0;
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
            o_err        <= 1'b0;
`endif
        end else begin
            case (state)
                // IDLE and DONE react identically to a start pulse; the only
                // difference is the o_done level left behind by a finished load.
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state        <= S_FILL;
                        o_debug_mode <= 1'b1;
                        o_core_rst   <= 1'b1;
                        o_byte_ready <= 1'b1;
                        o_done       <= 1'b0;
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
                        o_err        <= 1'b0;
`endif
                        addr         <= '0;
                        cnt          <= 2'd0;
                        last_seen    <= 1'b0;
                        o_wb_dbg_sel <= 4'h0;
                    end
                end

                S_FILL: begin
                    if (i_byte_valid && o_byte_ready) begin
                        o_wb_dbg_dat[8*cnt +: 8] <= i_byte;
                        o_wb_dbg_sel[cnt]        <= 1'b1;
                        cnt                      <= cnt + 2'd1;
                        last_seen                <= i_byte_last;
                        // A full word or the final byte launches the bus
                        // write on the very next cycle.
                        if (cnt == 2'd3 || i_byte_last) begin
                            state        <= S_WRITE;
                            o_byte_ready <= 1'b0;
                            o_wb_dbg_stb <= 1'b1;
                            o_wb_dbg_we  <= 1'b1;
                            o_wb_dbg_adr <= 32'(addr);
                        end
                    end
                end

                // The strobe is high for the whole of WRITE, so any ack seen
                // here belongs to this transaction.
                S_WRITE: begin
                    if (i_wb_dbg_ack) begin
                        o_wb_dbg_stb <= 1'b0;
                        o_wb_dbg_we  <= 1'b0;
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
                        // Address, data and lane enables stay put for the
                        // read-back; the idle strobe cycle separates the two
                        // transactions.
                        state        <= S_READ;
`else
                        o_wb_dbg_sel <= 4'h0;
                        cnt          <= 2'd0;
                        addr         <= addr + aw'(4);
                        if (word_final) begin
                            state        <= S_DONE;
                            o_debug_mode <= 1'b0;
                            o_core_rst   <= 1'b0;
                            o_done       <= 1'b1;
                        end else begin
                            state        <= S_FILL;
                            o_byte_ready <= 1'b1;
                        end
`endif
                    end
                end

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
                S_READ: begin
                    if (!o_wb_dbg_stb) begin
                        o_wb_dbg_stb <= 1'b1;
                    end else if (i_wb_dbg_ack) begin
                        o_wb_dbg_stb <= 1'b0;
                        o_wb_dbg_sel <= 4'h0;
                        cnt          <= 2'd0;
                        addr         <= addr + aw'(4);
                        if (!verify_ok || word_final) begin
                            state        <= S_DONE;
                            o_debug_mode <= 1'b0;
                            o_core_rst   <= 1'b0;
                            o_done       <= 1'b1;
                            o_err        <= !verify_ok;
                        end else begin
                            state        <= S_FILL;
                            o_byte_ready <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state        <= S_IDLE;
                    o_byte_ready <= 1'b0;
                    o_wb_dbg_stb <= 1'b0;
                    o_wb_dbg_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// -----------------------------------------------------------------------------
// Testbench for subservient_dbg_loader (memsize = 16).
// Directed sequence: reset, full word, single trailing byte, partial last word,
// capacity limit, last flag on the 4th byte, ack stall with mid-transaction
// reset and, when SUBSERVIENT_LOADER_VERIFY_EN is defined, read-back checks.
// A background bus responder acks strobes after ack_delay cycles, models the
// SRAM and logs every completed write.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_subservient_dbg_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_d;
    logic        valid;
    logic        last;
    logic [31:0] rdt;
    logic        ack_auto;
    logic        ack_stray;
    logic        ack;

    logic        o_byte_ready;
    logic        o_debug_mode;
    logic        o_core_rst;
    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic        o_done;
    logic        o_err;

    int n_checks;
    int n_errors;

    // Bus responder state
    int          ack_delay;
    int          wait_cnt;
    int          stall_viol;
    int          n_tx;
    int          n_rd;
    bit          rdt_zero;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic [31:0] mem [4];
    logic [31:0] tx_adr [16];
    logic [31:0] tx_dat [16];
    logic [3:0]  tx_sel [16];

    logic [31:0] exp_cap [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    assign ack = ack_auto | ack_stray;

    subservient_dbg_loader #(.memsize(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_byte       (byte_d),
        .i_byte_valid (valid),
        .i_byte_last  (last),
        .o_byte_ready (o_byte_ready),
        .o_debug_mode (o_debug_mode),
        .o_core_rst   (o_core_rst),
        .o_wb_dbg_adr (o_wb_dbg_adr),
        .o_wb_dbg_dat (o_wb_dbg_dat),
        .o_wb_dbg_sel (o_wb_dbg_sel),
        .o_wb_dbg_we  (o_wb_dbg_we),
        .o_wb_dbg_stb (o_wb_dbg_stb),
        .i_wb_dbg_rdt (rdt),
        .i_wb_dbg_ack (ack),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Bus responder: acks a strobe after ack_delay idle cycles, checks that the
    // request stays stable while stalled, models the SRAM and logs writes.
    initial begin
        ack_auto = 1'b0;
        rdt      = 32'h0;
        wait_cnt = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            ack_auto = 1'b0;
            if (rst || o_wb_dbg_stb !== 1'b1) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    cap_adr = o_wb_dbg_adr;
                    cap_dat = o_wb_dbg_dat;
                    cap_sel = o_wb_dbg_sel;
                end else if ({o_wb_dbg_adr, o_wb_dbg_dat, o_wb_dbg_sel} !== {cap_adr, cap_dat, cap_sel}) begin
                    stall_viol++;
                end
                if (wait_cnt >= ack_delay) begin
                    ack_auto = 1'b1;
                    if (o_wb_dbg_we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (o_wb_dbg_sel[i]) mem[o_wb_dbg_adr[3:2]][8*i +: 8] = o_wb_dbg_dat[8*i +: 8];
                        end
                        if (n_tx < 16) begin
                            tx_adr[n_tx] = o_wb_dbg_adr;
                            tx_dat[n_tx] = o_wb_dbg_dat;
                            tx_sel[n_tx] = o_wb_dbg_sel;
                        end
                        n_tx++;
                    end else begin
                        rdt = rdt_zero ? 32'h0 : mem[o_wb_dbg_adr[3:2]];
                        n_rd++;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte from a negedge; returns at the negedge after acceptance
    // or after the cycle budget runs out.
    task automatic send_byte(input logic [7:0] b, input logic l, output bit taken);
        taken  = 1'b0;
        byte_d = b;
        last   = l;
        valid  = 1'b1;
        for (int i = 0; i < 30 && !taken; i++) begin
            if (o_byte_ready === 1'b1) begin
                @(posedge clk);
                taken = 1'b1;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic l);
        bit taken;
        send_byte(b, l, taken);
        check(tag, 32'(taken), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && o_done !== 1'b1; i++) @(negedge clk);
        check(tag, 32'(o_done), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && o_byte_ready !== 1'b1; i++) @(negedge clk);
        check(tag, 32'(o_byte_ready), 32'd1);
    endtask

    initial begin
        bit taken;
        n_checks   = 0;
        n_errors   = 0;
        n_tx       = 0;
        n_rd       = 0;
        stall_viol = 0;
        ack_delay  = 0;
        rdt_zero   = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        valid      = 1'b0;
        last       = 1'b0;
        byte_d     = 8'h0;
        ack_stray  = 1'b0;

        // Reset held with random inputs: every output stays low.
        repeat (5) begin
            @(negedge clk);
            start     = 1'($urandom);
            valid     = 1'($urandom);
            last      = 1'($urandom);
            byte_d    = 8'($urandom);
            ack_stray = 1'($urandom);
        end
        @(negedge clk);
        check("rst_ctrl", 32'({o_debug_mode, o_core_rst, o_byte_ready, o_wb_dbg_stb,
                               o_wb_dbg_we, o_wb_dbg_sel, o_done, o_err}), 32'h0);
        check("rst_adr", o_wb_dbg_adr, 32'h0);
        check("rst_dat", o_wb_dbg_dat, 32'h0);
        start = 1'b0; valid = 1'b0; last = 1'b0; ack_stray = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores the stream and stray acks.
        valid = 1'b1; byte_d = 8'h5A; ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(o_byte_ready), 32'd0);
        check("idle_stb", 32'(o_wb_dbg_stb), 32'd0);
        check("idle_dbg", 32'({o_debug_mode, o_core_rst}), 32'd0);
        valid = 1'b0;

        // Full word.
        pulse_start();
        check("start_ctrl", 32'({o_debug_mode, o_core_rst, o_byte_ready, o_done}), 32'b1110);
        n_tx = 0;
        send("fw_b0", 8'h13, 1'b0);
        send("fw_b1", 8'h00, 1'b0);
        send("fw_b2", 8'h00, 1'b0);
        send("fw_b3", 8'h00, 1'b0);
        check("fw_latency", 32'({o_wb_dbg_stb, o_wb_dbg_we}), 32'b11);
        wait_ready("fw_refill");
        check("fw_ntx", n_tx, 1);
        check("fw_adr", tx_adr[0], 32'h0);
        check("fw_dat", tx_dat[0], 32'h00000013);
        check("fw_sel", 32'(tx_sel[0]), 32'hF);
        check("fw_busy", 32'({o_debug_mode, o_core_rst, o_done}), 32'b110);

        // Single trailing byte lands at address 4.
        send("tb_b0", 8'h55, 1'b1);
        wait_done("tb_done");
        check("tb_adr", tx_adr[1], 32'h4);
        check("tb_sel", 32'(tx_sel[1]), 32'h1);
        check("tb_dat", 32'(tx_dat[1][7:0]), 32'h55);
        check("tb_release", 32'({o_debug_mode, o_core_rst, o_byte_ready}), 32'b000);

        // Partial last word, restarted from DONE.
        pulse_start();
        check("pw_restart", 32'({o_done, o_debug_mode, o_byte_ready}), 32'b011);
        n_tx = 0;
        send("pw_b0", 8'hAA, 1'b0);
        send("pw_b1", 8'hBB, 1'b0);
        send("pw_b2", 8'hCC, 1'b0);
        send("pw_b3", 8'hDD, 1'b0);
        send("pw_b4", 8'h11, 1'b0);
        send("pw_b5", 8'h22, 1'b1);
        wait_done("pw_done");
        check("pw_ntx", n_tx, 2);
        check("pw_adr0", tx_adr[0], 32'h0);
        check("pw_dat0", tx_dat[0], 32'hDDCCBBAA);
        check("pw_sel0", 32'(tx_sel[0]), 32'hF);
        check("pw_adr1", tx_adr[1], 32'h4);
        check("pw_dat1", 32'(tx_dat[1][15:0]), 32'h2211);
        check("pw_sel1", 32'(tx_sel[1]), 32'h3);
        check("pw_release", 32'({o_debug_mode, o_core_rst}), 32'b00);

        // Capacity: 16 bytes fill the SRAM, the rest is refused.
        pulse_start();
        n_tx = 0;
        for (int k = 0; k < 16; k++) send("cap_byte", 8'(k), 1'b0);
        for (int k = 16; k < 20; k++) begin
            send_byte(8'(k), 1'b0, taken);
            check("cap_refused", 32'(taken), 32'd0);
        end
        check("cap_done", 32'({o_done, o_debug_mode, o_core_rst}), 32'b100);
        check("cap_ntx", n_tx, 4);
        for (int w = 0; w < 4; w++) begin
            check("cap_adr", tx_adr[w], 32'(4 * w));
            check("cap_dat", tx_dat[w], exp_cap[w]);
            check("cap_sel", 32'(tx_sel[w]), 32'hF);
        end

        // Last flag on the 4th byte: a single write, then DONE.
        pulse_start();
        n_tx = 0;
        send("l4_b0", 8'h01, 1'b0);
        send("l4_b1", 8'h02, 1'b0);
        send("l4_b2", 8'h03, 1'b0);
        send("l4_b3", 8'h04, 1'b1);
        wait_done("l4_done");
        check("l4_ntx", n_tx, 1);
        check("l4_dat", tx_dat[0], 32'h04030201);

        // Ack stall, then reset in the 3rd stalled cycle.
        pulse_start();
        n_tx       = 0;
        ack_delay  = 5;
        stall_viol = 0;
        send("st_b0", 8'hA1, 1'b0);
        send("st_b1", 8'hA2, 1'b0);
        send("st_b2", 8'hA3, 1'b0);
        send("st_b3", 8'hA4, 1'b0);
        check("st_stb", 32'(o_wb_dbg_stb), 32'd1);
        repeat (2) @(negedge clk);
        check("st_stable", stall_viol, 0);
        check("st_req", {o_wb_dbg_adr[7:0], o_wb_dbg_dat[23:0]}, 32'h00A3A2A1);
        #2 rst = 1'b1;
        #1;
        check("st_rst_bus", 32'({o_wb_dbg_stb, o_wb_dbg_we, o_wb_dbg_sel}), 32'h0);
        check("st_rst_dbg", 32'({o_debug_mode, o_core_rst}), 32'b00);
        check("st_no_ack", n_tx, 0);
        @(negedge clk);
        rst       = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        check("st_idle", 32'({o_byte_ready, o_wb_dbg_stb, o_done}), 32'b000);

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
        // Read-back returns zero for a written 0x13: error and release.
        pulse_start();
        n_rd     = 0;
        rdt_zero = 1'b1;
        send("vf_b0", 8'h13, 1'b0);
        send("vf_b1", 8'h00, 1'b0);
        send("vf_b2", 8'h00, 1'b0);
        send("vf_b3", 8'h00, 1'b0);
        wait_done("vf_done");
        check("vf_err", 32'(o_err), 32'd1);
        check("vf_nrd", n_rd, 1);
        check("vf_release", 32'({o_debug_mode, o_core_rst}), 32'b00);

        // Matching read-back: no error.
        pulse_start();
        check("vm_err_clr", 32'(o_err), 32'd0);
        rdt_zero = 1'b0;
        send("vm_b0", 8'h13, 1'b0);
        send("vm_b1", 8'h00, 1'b0);
        send("vm_b2", 8'h00, 1'b0);
        send("vm_b3", 8'h00, 1'b1);
        wait_done("vm_done");
        check("vm_err", 32'(o_err), 32'd0);
`else
        check("noverify_err", 32'(o_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
